// File: rtl/dcache_pkg.sv
// Shared state encoding and address helpers for the write-back cache line.
package dcache_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WRBACK = 2'd1,
    REFILL = 2'd2,
    FLUSH  = 2'd3
  } state_t;

  function automatic int max_ttl(input int bits);
    return (1 << bits) - 1;
  endfunction

  localparam int MAXTTL = max_ttl(8);

  // Both helpers work on a widened address so any ADDRBITS up to 64 fits.
  function automatic logic [63:0] tag_of(input logic [63:0] addr, input int cab);
    return addr >> (cab + 2);
  endfunction

  function automatic logic [63:0] word_of(input logic [63:0] addr, input int cab);
    return (addr >> 2) & ((64'd1 << cab) - 64'd1);
  endfunction

endpackage

// File: rtl/dcache_line_ram.sv
// Line storage: port A serves the CPU with byte lanes, port B serves refill and write-back.
// Both ports read through a register; the FSM never lets the two ports write in the same cycle.
module dcache_line_ram #(
  parameter int DATABITS      = 32,
  parameter int CACHEADDRBITS = 5
) (
  input  logic                     clk,
  input  logic                     a_we,
  input  logic [DATABITS/8-1:0]    a_be,
  input  logic [CACHEADDRBITS-1:0] a_addr,
  input  logic [DATABITS-1:0]      a_wdata,
  output logic [DATABITS-1:0]      a_rdata,
  input  logic                     b_we,
  input  logic [CACHEADDRBITS-1:0] b_addr,
  input  logic [DATABITS-1:0]      b_wdata,
  output logic [DATABITS-1:0]      b_rdata
);

  logic [DATABITS-1:0] mem [2**CACHEADDRBITS];

  always_ff @(posedge clk) begin
    if (a_we) begin
      for (int i = 0; i < DATABITS / 8; i++) begin
        if (a_be[i]) mem[a_addr][i*8 +: 8] <= a_wdata[i*8 +: 8];
      end
    end
    if (b_we) mem[b_addr] <= b_wdata;
    a_rdata <= mem[a_addr];
    b_rdata <= mem[b_addr];
  end

endmodule

// File: rtl/dcache_line_wb.sv
// Self-managing write-back cache line: tag/valid/dirty/age state plus miss and flush FSM.
// Define DCACHE_LINE_WB_STATS_EN to add saturating hit/miss counters.
module dcache_line_wb
  import dcache_pkg::*;
#(
  parameter int DATABITS      = 32,
  parameter int ADDRBITS      = 32,
  parameter int CACHEADDRBITS = 5,
  parameter int TTLBITS       = 8,
  parameter int STATBITS      = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [ADDRBITS-1:0]   cpu_addr,
  input  logic                  cpu_rdreq,
  input  logic                  cpu_wrreq,
  input  logic [DATABITS-1:0]   cpu_in,
  input  logic [DATABITS/8-1:0] cpu_byteenable,
  output logic [DATABITS-1:0]   cpu_out,
  output logic                  cpu_out_valid,
  output logic                  cpu_busy,
  output logic [ADDRBITS-1:0]   mem_addr,
  output logic                  mem_rdreq,
  output logic                  mem_wrreq,
  output logic [DATABITS-1:0]   mem_out,
  input  logic [DATABITS-1:0]   mem_in,
  input  logic                  mem_in_valid,
  input  logic                  mem_ack,
  input  logic                  flush_req,
  output logic                  flush_done,
  input  logic                  age_tick,
  output logic [TTLBITS-1:0]    line_ttl,
  output logic                  line_valid,
  output logic                  line_dirty,
  output state_t                dbg_state
`ifdef DCACHE_LINE_WB_STATS_EN
  ,
  output logic [STATBITS-1:0]   stat_hits,
  output logic [STATBITS-1:0]   stat_misses
`endif
);

  localparam int TAGBITS = ADDRBITS - CACHEADDRBITS - 2;
  localparam logic [TTLBITS-1:0] TTL_MAX = TTLBITS'(max_ttl(TTLBITS));

  state_t                     state, state_n;
  logic [TAGBITS-1:0]         r_tag;
  logic                       valid, dirty, wb_phase, flush_done_q, rd_valid_q;
  logic [TTLBITS-1:0]         ttl;
  logic [CACHEADDRBITS-1:0]   idx;
  logic [63:0]                tag_full, word_full;
  logic [TAGBITS-1:0]         req_tag;
  logic [CACHEADDRBITS-1:0]   req_word;
  logic                       req, hit, accept, last_word, miss_start;
  logic [DATABITS-1:0]        ram_a_q, ram_b_q;

  assign tag_full   = tag_of(64'(cpu_addr), CACHEADDRBITS);
  assign word_full  = word_of(64'(cpu_addr), CACHEADDRBITS);
  assign req_tag    = tag_full[TAGBITS-1:0];
  assign req_word   = word_full[CACHEADDRBITS-1:0];
  assign req        = cpu_rdreq | cpu_wrreq;
  assign hit        = valid & (req_tag == r_tag);
  assign cpu_busy   = (state != IDLE) | flush_req | (req & ~hit);
  assign accept     = req & ~cpu_busy;
  assign last_word  = (idx == '1);
  assign miss_start = (state == IDLE) & ~flush_req & req & ~hit;

  // Memory handshakes: mem_rdreq/mem_wrreq act as valid and hold address and
  // data steady; mem_in_valid/mem_ack act as ready and retire exactly one word.
  always_comb begin
    state_n   = state;
    mem_rdreq = 1'b0;
    mem_wrreq = 1'b0;
    mem_addr  = '0;
    unique case (state)
      IDLE: begin
        if (flush_req) begin
          if (dirty) state_n = FLUSH;
        end else if (miss_start) begin
          state_n = (dirty && valid) ? WRBACK : REFILL;
        end
      end
      WRBACK, FLUSH: begin
        if (wb_phase) begin
          mem_wrreq = 1'b1;
          mem_addr  = {r_tag, idx, 2'b00};
          if (mem_ack && last_word) state_n = (state == WRBACK) ? REFILL : IDLE;
        end
      end
      REFILL: begin
        mem_rdreq = 1'b1;
        mem_addr  = {r_tag, idx, 2'b00};
        if (mem_in_valid && last_word) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state        <= IDLE;
      r_tag        <= '0;
      valid        <= 1'b0;
      dirty        <= 1'b0;
      ttl          <= '0;
      idx          <= '0;
      wb_phase     <= 1'b0;
      flush_done_q <= 1'b0;
      rd_valid_q   <= 1'b0;
    end else begin
      state        <= state_n;
      flush_done_q <= 1'b0;
      rd_valid_q   <= accept & cpu_rdreq & ~cpu_wrreq;
      if (accept) ttl <= '0;
      else if (age_tick && ttl != TTL_MAX) ttl <= ttl + 1'b1;
      if (accept && cpu_wrreq) dirty <= 1'b1;
      unique case (state)
        IDLE: begin
          if (flush_req) begin
            idx      <= '0;
            wb_phase <= 1'b0;
            if (!dirty) begin
              valid        <= 1'b0;
              flush_done_q <= 1'b1;
            end
          end else if (miss_start) begin
            idx      <= '0;
            wb_phase <= 1'b0;
            if (!(dirty && valid)) begin
              r_tag <= req_tag;
              valid <= 1'b0;
            end
          end
        end
        WRBACK, FLUSH: begin
          // The first cycle of each word only loads the RAM read register.
          if (!wb_phase) begin
            wb_phase <= 1'b1;
          end else if (mem_ack) begin
            idx      <= idx + 1'b1;
            wb_phase <= 1'b0;
            if (last_word) begin
              valid <= 1'b0;
              dirty <= 1'b0;
              if (state == WRBACK) r_tag <= req_tag;
              else flush_done_q <= 1'b1;
            end
          end
        end
        REFILL: begin
          if (mem_in_valid) begin
            idx <= idx + 1'b1;
            if (last_word) begin
              valid <= 1'b1;
              dirty <= 1'b0;
              ttl   <= '0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  dcache_line_ram #(
    .DATABITS      (DATABITS),
    .CACHEADDRBITS (CACHEADDRBITS)
  ) u_ram (
    .clk     (clk),
    .a_we    (accept & cpu_wrreq),
    .a_be    (cpu_byteenable),
    .a_addr  (req_word),
    .a_wdata (cpu_in),
    .a_rdata (ram_a_q),
    .b_we    ((state == REFILL) & mem_in_valid),
    .b_addr  (idx),
    .b_wdata (mem_in),
    .b_rdata (ram_b_q)
  );

  assign cpu_out       = rd_valid_q ? ram_a_q : '0;
  assign cpu_out_valid = rd_valid_q;
  assign mem_out       = mem_wrreq ? ram_b_q : '0;
  assign flush_done    = flush_done_q;
  assign line_ttl      = ttl;
  assign line_valid    = valid;
  assign line_dirty    = dirty;
  assign dbg_state     = state;

`ifdef DCACHE_LINE_WB_STATS_EN
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      stat_hits   <= '0;
      stat_misses <= '0;
    end else begin
      if (accept && stat_hits != '1) stat_hits <= stat_hits + 1'b1;
      if (miss_start && stat_misses != '1) stat_misses <= stat_misses + 1'b1;
    end
  end
`endif

endmodule
